// File: rtl/cpu_pkg.sv
// Shared CPU definitions: timing-generator states, console run-mode code and
// default beat/counter sizes used by the timing generator and the decoder.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } cpu_state_e;

    localparam logic [1:0] CPUSTATE_RUN = 2'b11;

    localparam int NBEAT_DEF = 4;
    localparam int ICW_DEF   = 8;

endpackage

// File: rtl/beat_ring.sv
// One-hot beat ring: clear, load T1, hold or rotate by one position per edge.
// Any value that is not exactly one-hot is replaced by T1 when not cleared.
module beat_ring
    import cpu_pkg::*;
#(
    parameter int NBEAT = NBEAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load_t1,
    input  logic             advance,
    output logic [NBEAT-1:0] t
);

    localparam logic [NBEAT-1:0] T1 = {{(NBEAT-1){1'b0}}, 1'b1};

    logic [NBEAT-1:0] t_q;
    logic [NBEAT-1:0] t_d;
    logic             legal;

    always_comb begin
        legal = (t_q != '0) && ((t_q & (t_q - T1)) == '0);
        t_d   = t_q;
        if (clear) begin
            t_d = '0;
        end else if (load_t1 || !legal) begin
            // Holding an illegal value would lock the sequencer; restart at T1.
            t_d = T1;
        end else if (advance) begin
            t_d = {t_q[NBEAT-2:0], t_q[NBEAT-1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_q <= '0;
        end else begin
            t_q <= t_d;
        end
    end

    assign t = t_q;

endmodule

// File: rtl/cpu_timing_gen.sv
// CPU beat generator: sequences T1..Tn while run is enabled, counts completed
// instructions and raises stop_req on HLT or in single-step mode.
module cpu_timing_gen
    import cpu_pkg::*;
#(
    parameter int NBEAT = NBEAT_DEF,
    parameter int ICW   = ICW_DEF
) (
    input  logic             clk_choose,
    input  logic             rst,
    input  logic             run,
    input  logic [1:0]       cpustate,
    input  logic             step,
    input  logic             hlt,
    input  logic             cyc_end,
    output logic [NBEAT-1:0] T,
    output logic             instr_end,
    output logic             stop_req,
    output logic [ICW-1:0]   instr_cnt,
    output logic             busy
);

    cpu_state_e       state_q;
    cpu_state_e       state_d;
    logic             stop_req_q;
    logic             stop_req_d;
    logic [ICW-1:0]   instr_cnt_q;
    logic [ICW-1:0]   instr_cnt_d;
    logic             ring_clear;
    logic             ring_load;
    logic             ring_adv;
    logic             mode_ok;
    logic [NBEAT-1:0] t_ring;

    assign mode_ok   = (cpustate == CPUSTATE_RUN);
    assign instr_end = (state_q == RUN) && (t_ring[NBEAT-1] || (cyc_end && !t_ring[NBEAT-1]));

    always_comb begin
        state_d     = state_q;
        stop_req_d  = stop_req_q;
        instr_cnt_d = instr_cnt_q;
        ring_clear  = 1'b0;
        ring_load   = 1'b0;
        ring_adv    = 1'b0;
        case (state_q)
            IDLE: begin
                stop_req_d = 1'b0;
                if (run && mode_ok) begin
                    state_d   = RUN;
                    ring_load = 1'b1;
                end else begin
                    ring_clear = 1'b1;
                end
            end
            RUN: begin
                if (!mode_ok) begin
                    state_d    = IDLE;
                    stop_req_d = 1'b0;
                    ring_clear = 1'b1;
                end else if (!run) begin
                    // Pause: beat and count freeze, the instruction resumes later.
                    state_d = RUN;
                end else if (instr_end) begin
                    instr_cnt_d = instr_cnt_q + ICW'(1);
                    if (hlt || step) begin
                        state_d    = HALT;
                        stop_req_d = 1'b1;
                        ring_clear = 1'b1;
                    end else begin
                        ring_load = 1'b1;
                    end
                end else begin
                    ring_adv = 1'b1;
                end
            end
            HALT: begin
                ring_clear = 1'b1;
                // Held until run drops, which outlasts the two-stage clr sync.
                if (!mode_ok || !run) begin
                    state_d    = IDLE;
                    stop_req_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                stop_req_d = 1'b0;
                ring_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_choose or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            stop_req_q  <= 1'b0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stop_req_q  <= stop_req_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    beat_ring #(
        .NBEAT (NBEAT)
    ) u_ring (
        .clk     (clk_choose),
        .rst     (rst),
        .clear   (ring_clear),
        .load_t1 (ring_load),
        .advance (ring_adv),
        .t       (t_ring)
    );

    assign T         = t_ring;
    assign stop_req  = stop_req_q;
    assign instr_cnt = instr_cnt_q;
    assign busy      = (state_q == RUN);

endmodule
